// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: brings an asynchronous level into the clk domain. Only the
//          second stage (q) may be used by downstream logic.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset; both stages load RESET_VAL
//   d    - asynchronous input
//   q    - synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/simple_uart_rx.sv
// rtl/simple_uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing/break detection
//
// Purpose: receives 8N1 frames on rxd, sampling each bit near its centre
//          with a down-counter, and presents each byte with a one-cycle
//          valid pulse. A low stop bit gives one frame_err pulse; the
//          receiver then waits for the line to go high again so a held-low
//          line (break) reports only once.
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit, 8..1023
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   rxd       - asynchronous serial line, idle high
//   dat       - last received byte, held until the next valid
//   valid     - one-cycle pulse, new byte in dat
//   frame_err - one-cycle pulse, stop bit sampled low
//   busy      - high while a frame is in progress (state != IDLE)
module simple_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dat,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic rx_s2;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s2)
    );

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       dat_q,       dat_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;

    logic tick;

    // The counter is only meaningful while timing a bit; in IDLE and
    // BREAK it holds and tick is ignored.
    assign tick = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        dat_d       = dat_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            if (tick) begin
                cnt_d = CNT_RELOAD;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s2) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects short glitches on the line.
                if (tick) begin
                    if (rx_s2) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = rx_s2;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of
                // margin to catch a back-to-back start edge.
                if (tick) begin
                    if (rx_s2) begin
                        dat_d   = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            dat_q       <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dat       = dat_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_simple_uart_rx.sv
// tb/tb_simple_uart_rx.sv - self-checking bench for simple_uart_rx at 16 clocks per bit
module tb_simple_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] dat;
    logic       valid;
    logic       frame_err;
    logic       busy;

    simple_uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .dat       (dat),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_valid  = 0;
    int         n_fe     = 0;
    int         busy_cnt = 0;
    bit         stress   = 1'b0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];
    int         vt_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every valid pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (frame_err) n_fe++;
            if (valid) begin
                n_valid++;
                vt_q.push_back(cyc);
                if (!stress) begin
                    check("valid_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("dat", 32'(dat), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Drives nslots of the frame {stop, b, start}; slot i starts at round(i*p100/100).
    task automatic send_frame(input logic [7:0] b, input int p100, input logic stop_v,
                              input int nslots, input bit expect_it);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        if (expect_it) begin
            exp_q.push_back(b);
            last_good = b;
        end
        for (int i = 0; i < nslots; i++) begin
            int dur;
            dur = ((i + 1) * p100 + 50) / 100 - (i * p100 + 50) / 100;
            rxd = fr[i];
            repeat (dur) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        int stress_p[3];
        stress_p[0] = 1600;
        stress_p[1] = 1500;
        stress_p[2] = 1700;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_dat", 32'(dat), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte
        v0 = n_valid; f0 = n_fe; busy_cnt = 0;
        send_frame(8'hA5, 1600, 1'b1, 10, 1'b1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        wait_idle();
        check("a5_valid_cnt", 32'(n_valid - v0), 1);
        check("a5_fe_cnt", 32'(n_fe - f0), 0);
        check("a5_dat", 32'(dat), 32'h a5);
        check("a5_busy_len_152pm1", 32'(busy_cnt >= 151 && busy_cnt <= 153), 1);

        // Back-to-back frames with no idle gap
        vt_q.delete();
        v0 = n_valid;
        send_frame(8'h00, 1600, 1'b1, 10, 1'b1);
        send_frame(8'hFF, 1600, 1'b1, 10, 1'b1);
        send_frame(8'h55, 1600, 1'b1, 10, 1'b1);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        wait_idle();
        check("b2b_valid_cnt", 32'(n_valid - v0), 3);
        check("b2b_times", 32'(vt_q.size()), 3);
        if (vt_q.size() == 3) begin
            check("b2b_gap0", 32'((vt_q[1] - vt_q[0]) >= 159 && (vt_q[1] - vt_q[0]) <= 161), 1);
            check("b2b_gap1", 32'((vt_q[2] - vt_q[1]) >= 159 && (vt_q[2] - vt_q[1]) <= 161), 1);
        end

        // Start glitch: 4 cycles low
        v0 = n_valid; f0 = n_fe;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_rise", 32'(busy), 1);
        @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy_d7", 32'(busy), 1);
        @(negedge clk);
        check("glitch_busy_d8", 32'(busy), 0);
        repeat (200) @(negedge clk);
        check("glitch_no_valid", 32'(n_valid - v0), 0);
        check("glitch_no_fe", 32'(n_fe - f0), 0);

        // Stop bit forced low, then a good byte
        v0 = n_valid; f0 = n_fe;
        send_frame(8'h3C, 1600, 1'b0, 10, 1'b0);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        check("stop0_fe_cnt", 32'(n_fe - f0), 1);
        check("stop0_no_valid", 32'(n_valid - v0), 0);
        check("stop0_dat_held", 32'(dat), 32'(last_good));
        check("stop0_idle", 32'(busy), 0);
        send_frame(8'h81, 1600, 1'b1, 10, 1'b1);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        wait_idle();
        check("after_stop0_dat", 32'(dat), 32'h81);

        // Break: 40 bit times low, then a good byte
        v0 = n_valid; f0 = n_fe;
        rxd = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h12, 1600, 1'b1, 10, 1'b1);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        wait_idle();
        check("break_fe_cnt", 32'(n_fe - f0), 1);
        check("break_valid_cnt", 32'(n_valid - v0), 1);
        check("break_dat", 32'(dat), 32'h12);

        // Reset during DATA, then 7E at nominal and +-6% transmitter rates
        for (int k = 0; k < 3; k++) begin
            v0 = n_valid; f0 = n_fe;
            send_frame(8'hC3, 1600, 1'b1, 4, 1'b0);
            rst = 1'b1;
            rxd = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            check("abort_busy", 32'(busy), 0);
            check("abort_dat_cleared", 32'(dat), 0);
            repeat (20) @(negedge clk);
            check("abort_no_pulse", 32'((n_valid - v0) + (n_fe - f0)), 0);
            stress = (stress_p[k] != 1600);
            v0 = n_valid; f0 = n_fe;
            send_frame(8'h7E, stress_p[k], 1'b1, 10, !stress);
            rxd = 1'b1;
            repeat (40) @(negedge clk);
            wait_idle();
            if (stress) begin
                check("stress_one_pulse", 32'((n_valid - v0) + (n_fe - f0)), 1);
            end else begin
                check("nominal_7e_valid", 32'(n_valid - v0), 1);
                check("nominal_7e_dat", 32'(dat), 32'h7e);
            end
            stress = 1'b0;
            repeat (32) @(negedge clk);
        end

        // +-2% transmitter clock offset must decode correctly
        v0 = n_valid; f0 = n_fe;
        send_frame(8'h7E, 1568, 1'b1, 10, 1'b1);
        send_frame(8'hB4, 1632, 1'b1, 10, 1'b1);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        wait_idle();
        check("tol_valid_cnt", 32'(n_valid - v0), 2);
        check("tol_fe_cnt", 32'(n_fe - f0), 0);
        check("tol_dat", 32'(dat), 32'hb4);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
